// File: rtl/ai_scan_if.sv
// Controller <-> ai_scan bundle: start/board request and the registered move result.
// The controller holds the master modport and the move selector holds the slave modport.
interface ai_scan_if #(
    parameter int N = 3
);
    localparam int RC_W = $clog2(N);

    logic                  start;
    logic [2*N*N-1:0]      board;
    logic                  busy;
    logic                  done;
    logic [RC_W-1:0]       row;
    logic [RC_W-1:0]       col;
    logic [2:0]            move_kind;
    logic                  no_move;

    modport master (
        output start, board,
        input  busy, done, row, col, move_kind, no_move
    );

    modport slave (
        input  start, board,
        output busy, done, row, col, move_kind, no_move
    );
endinterface

// File: rtl/ai_scan.sv
// Sequential NxN tic-tac-toe move selector: snapshot, one line scan per clock, then priority pick.
// Optional AI_LFSR_EN: an 8-bit LFSR rotates the corner search start point per request.
module ai_scan #(
    parameter int         N       = 3,
    parameter logic [1:0] AI_CODE = 2'b10
) (
    input logic      clk,
    input logic      rst_n,
    ai_scan_if.slave bus
);
    localparam int         RC_W     = $clog2(N);
    localparam int         LINES    = 2*N + 2;
    localparam int         LW       = $clog2(LINES);
    localparam int         CW       = $clog2(N + 1);
    localparam logic [1:0] OPP_CODE = 2'b01;
    localparam logic [1:0] EMPTY    = 2'b00;

    generate
        if (N < 3 || N > 8) begin : g_bad_n
            $error("ai_scan: N must be in the range 3..8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, PICK, DONE} state_t;
    state_t state, state_nx;

    logic [2*N*N-1:0] snap;
    logic [LW-1:0]    line;
    logic             win_found, block_found;
    logic [RC_W-1:0]  win_row, win_col, block_row, block_col;
    logic [RC_W-1:0]  row_q, col_q;
    logic [2:0]       kind_q;
    logic             none_q;
    logic [1:0]       corner_start;
    logic             busy, done;

    // Lines 0..N-1 are rows, N..2N-1 columns, 2N the main diagonal, 2N+1 the anti diagonal.
    function automatic int line_row(input int l, input int k);
        if (l < N) return l;
        return k;
    endfunction

    function automatic int line_col(input int l, input int k);
        if (l < N)      return k;
        if (l < 2*N)    return l - N;
        if (l == 2*N)   return k;
        return N - 1 - k;
    endfunction

    function automatic logic [1:0] cell_of(input logic [2*N*N-1:0] b, input int r, input int c);
        logic [2*N*N-1:0] sh;
        sh = b >> (2*(N*r + c));
        return sh[1:0];
    endfunction

    function automatic int corner_r(input logic [1:0] idx);
        return idx[1] ? N - 1 : 0;
    endfunction

    function automatic int corner_c(input logic [1:0] idx);
        return idx[0] ? N - 1 : 0;
    endfunction

    logic [CW-1:0]   ai_cnt, opp_cnt, empty_cnt;
    logic [RC_W-1:0] empty_row, empty_col;
    logic [1:0]      scan_cell;
    logic            win_hit, block_hit;

    always_comb begin
        ai_cnt    = '0;
        opp_cnt   = '0;
        empty_cnt = '0;
        empty_row = '0;
        empty_col = '0;
        scan_cell = EMPTY;
        for (int k = 0; k < N; k++) begin
            scan_cell = cell_of(snap, line_row(int'(line), k), line_col(int'(line), k));
            if (scan_cell == EMPTY) begin
                empty_cnt = empty_cnt + CW'(1);
                empty_row = RC_W'(line_row(int'(line), k));
                empty_col = RC_W'(line_col(int'(line), k));
            end else if (scan_cell == AI_CODE) begin
                ai_cnt = ai_cnt + CW'(1);
            end else if (scan_cell == OPP_CODE) begin
                opp_cnt = opp_cnt + CW'(1);
            end
        end
        win_hit   = (ai_cnt  == CW'(N - 1)) && (empty_cnt == CW'(1));
        block_hit = (opp_cnt == CW'(N - 1)) && (empty_cnt == CW'(1));
    end

    logic [RC_W-1:0] pick_row, pick_col;
    logic [2:0]      pick_kind;
    logic            pick_none;
    logic [1:0]      corner_idx;

    // Lowest priority is applied first; each higher-priority candidate overrides it.
    always_comb begin
        pick_row   = '0;
        pick_col   = '0;
        pick_kind  = 3'd7;
        pick_none  = 1'b1;
        corner_idx = 2'd0;
        for (int i = N*N - 1; i >= 0; i--) begin
            if (cell_of(snap, i / N, i % N) == EMPTY) begin
                pick_row  = RC_W'(i / N);
                pick_col  = RC_W'(i % N);
                pick_kind = 3'd4;
                pick_none = 1'b0;
            end
        end
        for (int j = 3; j >= 0; j--) begin
            corner_idx = 2'(int'(corner_start) + j);
            if (cell_of(snap, corner_r(corner_idx), corner_c(corner_idx)) == EMPTY) begin
                pick_row  = RC_W'(corner_r(corner_idx));
                pick_col  = RC_W'(corner_c(corner_idx));
                pick_kind = 3'd3;
            end
        end
        if ((N % 2) == 1) begin
            if (cell_of(snap, N / 2, N / 2) == EMPTY) begin
                pick_row  = RC_W'(N / 2);
                pick_col  = RC_W'(N / 2);
                pick_kind = 3'd2;
            end
        end
        if (block_found) begin
            pick_row  = block_row;
            pick_col  = block_col;
            pick_kind = 3'd1;
        end
        if (win_found) begin
            pick_row  = win_row;
            pick_col  = win_col;
            pick_kind = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (line == LW'(LINES - 1)) state_nx = PICK;
            end
            PICK: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap        <= '0;
            line        <= '0;
            win_found   <= 1'b0;
            block_found <= 1'b0;
            win_row     <= '0;
            win_col     <= '0;
            block_row   <= '0;
            block_col   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            kind_q      <= 3'd0;
            none_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    snap        <= bus.board;
                    line        <= '0;
                    win_found   <= 1'b0;
                    block_found <= 1'b0;
                end
                SCAN: begin
                    if (win_hit && !win_found) begin
                        win_found <= 1'b1;
                        win_row   <= empty_row;
                        win_col   <= empty_col;
                    end
                    if (block_hit && !block_found) begin
                        block_found <= 1'b1;
                        block_row   <= empty_row;
                        block_col   <= empty_col;
                    end
                    line <= line + LW'(1);
                end
                PICK: begin
                    row_q  <= pick_row;
                    col_q  <= pick_col;
                    kind_q <= pick_kind;
                    none_q <= pick_none;
                end
                default: ;
            endcase
        end
    end

`ifdef AI_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr         <= 8'h01;
            corner_start <= 2'd0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state == IDLE && bus.start) corner_start <= lfsr[1:0];
        end
    end
`else
    assign corner_start = 2'd0;
`endif

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.row       = row_q;
    assign bus.col       = col_q;
    assign bus.move_kind = kind_q;
    assign bus.no_move   = none_q;
endmodule

// File: tb/tb_ai_scan.sv
// Directed-vector bench for ai_scan (N=3 main instance, N=4 instance for the even-N corner case).
// Board strings are row-major: A = AI (10), O = opponent (01), # = 11, . = empty.
module tb_ai_scan;
    typedef struct {
        string      name;
        logic [17:0] board;
        int         exp_row;
        int         exp_col;
        int         exp_kind;
        int         exp_none;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ai_scan_if #(.N(3)) bus ();
    ai_scan_if #(.N(4)) bus4 ();

    ai_scan #(.N(3), .AI_CODE(2'b10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ai_scan #(.N(4), .AI_CODE(2'b10)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int   checks = 0;
    int   errors = 0;
    int   prev_row = 0;
    vec_t vecs [11];

    function automatic logic [17:0] b3(input string s);
        logic [17:0] b;
        logic [1:0]  code;
        b = '0;
        for (int i = 0; i < 9; i++) begin
            case (s[i])
                "A":     code = 2'b10;
                "O":     code = 2'b01;
                "#":     code = 2'b11;
                default: code = 2'b00;
            endcase
            b = b | (18'(code) << (2*i));
        end
        return b;
    endfunction

    function automatic vec_t mk(input string n, input string s, input int r, input int c,
                                input int k, input int none);
        vec_t v;
        v.name = n;  v.board = b3(s);
        v.exp_row = r; v.exp_col = c; v.exp_kind = k; v.exp_none = none;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Starts one request, scrambles the board after it is latched, waits (bounded) for done.
    task automatic applyStimulus(input logic [17:0] board, input string name, output int lat);
        @(negedge clk);
        bus.board = board;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.board = ~board;
        lat = 1;
        checkOutput({name, " busy after start"}, int'(bus.busy), 1);
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) checkOutput({name, " row held mid-scan"}, int'(bus.row), prev_row);
        end
        checkOutput({name, " latency"}, lat, 10);
    endtask

    task automatic runVec(input vec_t v);
        int lat;
        applyStimulus(v.board, v.name, lat);
        checkOutput({v.name, " row"},       int'(bus.row),       v.exp_row);
        checkOutput({v.name, " col"},       int'(bus.col),       v.exp_col);
        checkOutput({v.name, " move_kind"}, int'(bus.move_kind), v.exp_kind);
        checkOutput({v.name, " no_move"},   int'(bus.no_move),   v.exp_none);
        checkOutput({v.name, " busy at done"}, int'(bus.busy), 0);
        prev_row = v.exp_row;
        @(posedge clk); #1;
        checkOutput({v.name, " done one cycle"}, int'(bus.done), 0);
    endtask

    initial begin
        int lat;
        int done_cnt;

        vecs[0]  = mk("win",          "AA.O..O..", 0, 2, 0, 0);
        vecs[1]  = mk("block",        "A..OO....", 1, 2, 1, 0);
        vecs[2]  = mk("win over blk", "A..OO.AA.", 2, 2, 0, 0);
        vecs[3]  = mk("empty board",  ".........", 1, 1, 2, 0);
        vecs[4]  = mk("center opp",   "....O....", 0, 0, 3, 0);
        vecs[5]  = mk("corner TR",    "A...O....", 0, 2, 3, 0);
        vecs[6]  = mk("full board",   "AOAAOOOAO", 0, 0, 7, 1);
        vecs[7]  = mk("lowest win",   "AA.AA....", 0, 2, 0, 0);
        vecs[8]  = mk("lowest block", "OO..O...A", 0, 2, 1, 0);
        vecs[9]  = mk("code11 first", "#.#.#.#.#", 0, 1, 4, 0);
        vecs[10] = mk("code11 row",   "AA#......", 1, 1, 2, 0);

        bus.start  = 1'b0;
        bus.board  = '0;
        bus4.start = 1'b0;
        bus4.board = '0;
        rst_n      = 1'b0;
        #12;
        checkOutput("reset busy",      int'(bus.busy),      0);
        checkOutput("reset done",      int'(bus.done),      0);
        checkOutput("reset row",       int'(bus.row),       0);
        checkOutput("reset col",       int'(bus.col),       0);
        checkOutput("reset move_kind", int'(bus.move_kind), 0);
        checkOutput("reset no_move",   int'(bus.no_move),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) runVec(vecs[i]);

        // Extra starts during scan and during the done cycle must not produce a second done.
        @(negedge clk);
        bus.board = b3(".........");
        bus.start = 1'b1;
        done_cnt  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
            bus.start = (cyc == 3 || cyc == 9);
        end
        bus.start = 1'b0;
        checkOutput("start while busy done count", done_cnt, 1);
        checkOutput("start while busy move_kind", int'(bus.move_kind), 2);
        prev_row = 1;

        // Reset in the middle of a scan aborts without a done pulse.
        @(negedge clk);
        bus.board = b3("AA.O..O..");
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy",      int'(bus.busy),      0);
        checkOutput("abort done",      int'(bus.done),      0);
        checkOutput("abort row",       int'(bus.row),       0);
        checkOutput("abort move_kind", int'(bus.move_kind), 0);
        prev_row = 0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        checkOutput("abort no done", done_cnt, 0);
        runVec(vecs[1]);

        // Even N: no center step, first corner TL, latency 2N+4 = 12.
        @(negedge clk);
        bus4.board = '0;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        lat = 1;
        while (!bus4.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("N4 latency",   lat, 12);
        checkOutput("N4 move_kind", int'(bus4.move_kind), 3);
        checkOutput("N4 row",       int'(bus4.row), 0);
        checkOutput("N4 col",       int'(bus4.col), 0);
        checkOutput("N4 no_move",   int'(bus4.no_move), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
